servo_pwm_gen: RTL and testbench

//  Downstream of the 20-bit frame counter (0..999999, 20 ms @ 50 MHz). Accepts angle

---
 rtl/servo_pkg.sv | 24 ++
 rtl/servo_pwm_gen_if.sv | 12 +
 rtl/servo_angle2pw.sv | 18 +
 rtl/servo_pwm_gen.sv | 119 +++++++++++
 tb/tb_servo_pwm_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared constants, state encoding and angle clamp for the servo PWM generator.
package servo_pkg;

  localparam int unsigned CNT_W      = 20;
  localparam int unsigned ANG_W      = 8;
  localparam int unsigned FRAME_LAST = 999999;
  localparam int unsigned PW_MIN     = 50000;
  localparam int unsigned PW_MAX     = 100000;
  localparam int unsigned PW_CENTER  = 75000;
  localparam int unsigned DEG_TICKS  = 278;
  localparam int unsigned ANGLE_MAX  = 180;
  localparam int unsigned SLEW_TICKS = 2780;

  typedef enum logic {
    HOLD   = 1'b0,
    MOVING = 1'b1
  } servo_state_e;

  // Saturate a commanded angle to the mechanical range.
  function automatic logic [ANG_W-1:0] clamp_angle(input logic [ANG_W-1:0] angle);
    return (angle > ANG_W'(ANGLE_MAX)) ? ANG_W'(ANGLE_MAX) : angle;
  endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Angle command handshake between a controller and the servo PWM generator.
interface servo_pwm_gen_if;
  import servo_pkg::*;

  logic             cmd_valid;
  logic [ANG_W-1:0] cmd_angle;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_angle, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_angle, output cmd_ready);

endinterface

// File: rtl/servo_angle2pw.sv
// Combinational angle-to-pulse-width map: clamp, linear scale, saturate at PW_MAX.
module servo_angle2pw
  import servo_pkg::*;
(
  input  logic [ANG_W-1:0] angle,
  output logic [CNT_W-1:0] width_c
);

  logic [ANG_W-1:0] ang_clamped;
  logic [CNT_W-1:0] raw;

  always_comb begin
    ang_clamped = clamp_angle(angle);
    raw         = CNT_W'(PW_MIN) + CNT_W'(ang_clamped) * CNT_W'(DEG_TICKS);
    width_c     = (raw > CNT_W'(PW_MAX)) ? CNT_W'(PW_MAX) : raw;
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: buffers one angle command, commits widths at frame boundaries.
// Optional slew limiting of the width per frame is enabled by defining SERVO_SLEW_EN.
module servo_pwm_gen
  import servo_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [CNT_W-1:0] condiv,
  servo_pwm_gen_if.slave   cmd,
  output logic             pwm,
  output logic             busy,
  output logic [CNT_W-1:0] pw_cur,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LAST);
  localparam logic [CNT_W-1:0] CENTER_W  = CNT_W'(PW_CENTER);

  servo_state_e     state_q, state_d;
  logic             pend_full_q;
  logic [ANG_W-1:0] pend_angle_q;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] pw_d;
  logic [CNT_W-1:0] pend_width_c;
  logic             frame_end_c;
  logic             accept_c;

  servo_angle2pw u_angle2pw (
    .angle   (pend_angle_q),
    .width_c (pend_width_c)
  );

  assign frame_end_c   = (condiv == FRAME_END);
  assign accept_c      = cmd.cmd_valid & ~pend_full_q;
  assign cmd.cmd_ready = ~pend_full_q;
  assign busy          = pend_full_q | (state_q == MOVING);

  // Target seen by the width update: the pending width if it is being committed now.
  always_comb begin
    target_d = target_q;
    if (frame_end_c && pend_full_q) target_d = pend_width_c;
  end

`ifdef SERVO_SLEW_EN
  localparam logic [CNT_W-1:0] SLEW_W = CNT_W'(SLEW_TICKS);

  logic [CNT_W-1:0] dist_c;
  logic [CNT_W-1:0] step_c;
  logic             near_c;

  always_comb begin
    dist_c = (target_d >= pw_cur) ? (target_d - pw_cur) : (pw_cur - target_d);
    step_c = (target_d > pw_cur) ? (pw_cur + SLEW_W) : (pw_cur - SLEW_W);
    near_c = (dist_c <= SLEW_W);
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= HOLD;
    else        state_q <= state_d;
  end

  // Width FSM; only advances on the frame-end tick.
  always_comb begin
    state_d = state_q;
    pw_d    = pw_cur;
    if (frame_end_c) begin
`ifdef SERVO_SLEW_EN
      case (state_q)
        HOLD: begin
          if (target_d != pw_cur) begin
            if (near_c) begin
              pw_d = target_d;
            end else begin
              state_d = MOVING;
              pw_d    = step_c;
            end
          end
        end
        MOVING: begin
          if (near_c) begin
            state_d = HOLD;
            pw_d    = target_d;
          end else begin
            pw_d = step_c;
          end
        end
        default: state_d = HOLD;
      endcase
`else
      pw_d = target_d;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_full_q  <= 1'b0;
      pend_angle_q <= '0;
      target_q     <= CENTER_W;
      pw_cur       <= CENTER_W;
      pwm          <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      target_q   <= target_d;
      pw_cur     <= pw_d;
      pwm        <= (condiv < pw_cur);
      frame_tick <= frame_end_c;
      // Accept only happens with the buffer empty, so it never collides with the clear.
      if (accept_c) begin
        pend_full_q  <= 1'b1;
        pend_angle_q <= clamp_angle(cmd.cmd_angle);
      end else if (frame_end_c) begin
        pend_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed plus randomized bench for servo_pwm_gen; condiv fast-forwards between
// the boundary points of each frame so a frame costs only a handful of cycles.
module tb_servo_pwm_gen;

  localparam int FRAME_LAST = 999999;
  localparam int PW_MIN     = 50000;
  localparam int PW_MAX     = 100000;
  localparam int PW_CENTER  = 75000;
  localparam int DEG_TICKS  = 278;
  localparam int ANGLE_MAX  = 180;
  localparam int SLEW       = 2780;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic [19:0] condiv = '0;
  logic        pwm, busy, frame_tick;
  logic [19:0] pw_cur;

  servo_pwm_gen_if cmd_if ();

  servo_pwm_gen dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .condiv     (condiv),
    .cmd        (cmd_if),
    .pwm        (pwm),
    .busy       (busy),
    .pw_cur     (pw_cur),
    .frame_tick (frame_tick)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_pend;
  int m_pend_ang;
  int m_target;
  int m_pw;
  bit m_pwm;
  bit m_tick;
  int txq[$];

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  function automatic int width_of(input int angle);
    int a;
    int w;
    a = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
    w = PW_MIN + a * DEG_TICKS;
    return (w > PW_MAX) ? PW_MAX : w;
  endfunction

  function automatic int approach(input int cur, input int tgt);
    if (tgt > cur + SLEW) return cur + SLEW;
    if (tgt < cur - SLEW) return cur - SLEW;
    return tgt;
  endfunction

  function automatic bit exp_busy();
    return m_pend || (SLEW_ON && (m_pw != m_target));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, ".pwm"},        32'(pwm),           32'(m_pwm));
    chk({ctx, ".frame_tick"}, 32'(frame_tick),    32'(m_tick));
    chk({ctx, ".pw_cur"},     32'(pw_cur),        32'(m_pw));
    chk({ctx, ".busy"},       32'(busy),          32'(exp_busy()));
    chk({ctx, ".cmd_ready"},  32'(cmd_if.cmd_ready), 32'(!m_pend));
  endtask

  task automatic model_reset();
    m_pend   = 1'b0;
    m_target = PW_CENTER;
    m_pw     = PW_CENTER;
    m_pwm    = 1'b0;
    m_tick   = 1'b0;
  endtask

  // One clock with condiv = cv; the model applies the same edge, outputs checked #1 later.
  task automatic step(input int cv);
    bit acc;
    @(negedge CLK);
    if (!cmd_if.cmd_valid && txq.size() > 0) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_angle = 8'(txq.pop_front());
    end
    condiv = 20'(cv);
    @(posedge CLK);
    acc    = cmd_if.cmd_valid && !m_pend;
    m_pwm  = (cv < m_pw);
    m_tick = (cv == FRAME_LAST);
    if (cv == FRAME_LAST) begin
      if (m_pend) begin
        m_target = width_of(m_pend_ang);
        m_pend   = 1'b0;
      end
      m_pw = SLEW_ON ? approach(m_pw, m_target) : m_target;
    end
    if (acc) begin
      m_pend     = 1'b1;
      m_pend_ang = int'(cmd_if.cmd_angle);
    end
    #1;
    if (acc) cmd_if.cmd_valid = 1'b0;
    chk_all("step");
  endtask

  // One frame visiting its boundary points in counting order.
  task automatic run_frame(input bit cmd_at_end, input int ang);
    int pts[$];
    int prev;
    pts = '{0, 1, 30000, m_pw - 1, m_pw, m_pw + 1,
            int'($urandom_range(2, FRAME_LAST - 2)), FRAME_LAST - 1, FRAME_LAST};
    pts.sort();
    prev = -1;
    foreach (pts[i]) begin
      if (pts[i] != prev) begin
        if (cmd_at_end && pts[i] == FRAME_LAST) txq.push_back(ang);
        step(pts[i]);
      end
      prev = pts[i];
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    txq.delete();
    cmd_if.cmd_valid = 1'b0;
    model_reset();
    #1;
    chk_all("reset");
    @(negedge CLK);
    condiv = '0;
    RST_N  = 1'b1;
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_angle = '0;
    model_reset();

    // Power-on reset
    #2 RST_N = 1'b0;
    #1;
    chk_all("por");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Idle frames hold the centre width
    run_frame(1'b0, 0);
    run_frame(1'b0, 0);
    chk("idle_pw", 32'(pw_cur), 32'd75000);

    // Angle 180 saturates at PW_MAX
    txq.push_back(180);
    run_frame(1'b0, 0);
    chk("a180_pw", 32'(pw_cur), SLEW_ON ? 32'd77780 : 32'd100000);
    run_frame(1'b0, 0);
    run_frame(1'b0, 0);

    // Angle 0 from centre: 2780 ticks per frame under slew, reaching 50000 on frame 9
    apply_reset();
    txq.push_back(0);
    for (int j = 1; j <= 10; j++) begin
      run_frame(1'b0, 0);
      if (SLEW_ON) begin
        chk("a0_pw", 32'(pw_cur), 32'((75000 - 2780 * j < 50000) ? 50000 : 75000 - 2780 * j));
        chk("a0_busy", 32'(busy), 32'(j < 9));
      end else begin
        chk("a0_pw", 32'(pw_cur), 32'd50000);
        chk("a0_busy", 32'(busy), 32'd0);
      end
    end

    // Angle 250 clamps; a second command is held off while the buffer is full
    apply_reset();
    txq.push_back(250);
    txq.push_back(30);
    step(0);
    step(1);
    chk("held_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("held_busy", 32'(busy), 32'd1);
    step(FRAME_LAST);
    chk("a250_pw", 32'(pw_cur), SLEW_ON ? 32'd77780 : 32'd100000);
    run_frame(1'b0, 0);
    chk("a30_pw", 32'(pw_cur), SLEW_ON ? 32'd75000 : 32'd58340);

    // Accept coincident with the frame-end tick lands one frame later
    apply_reset();
    run_frame(1'b1, 45);
    chk("coin_pw", 32'(pw_cur), 32'd75000);
    chk("coin_ready", 32'(cmd_if.cmd_ready), 32'd0);
    run_frame(1'b0, 0);
    chk("coin_applied", 32'(pw_cur), SLEW_ON ? 32'd72220 : 32'd62510);

    // Reset mid-pulse drops pwm and discards the pending command
    apply_reset();
    txq.push_back(10);
    step(0);
    step(30000);
    chk("mid_pwm_high", 32'(pwm), 32'd1);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk_all("midrst");
    @(negedge CLK);
    condiv = '0;
    RST_N  = 1'b1;
    run_frame(1'b0, 0);
    run_frame(1'b0, 0);
    chk("midrst_pw", 32'(pw_cur), 32'd75000);

    // Randomized command traffic
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) txq.push_back(int'($urandom_range(0, 255)));
      run_frame($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
